ub_access_arbiter: RTL and testbench

Shares the single unified-buffer command port between up to `NREQ` requesters: host load path, ST_UB accumulator write-back and systolic/VPU activation fetch. It is a round-robin, burst-locked scheduler that sits between the instruction controller's requesters and the `unified_buffer` instance in `tpu_datapath`. A won burst owns the buffer until `ub_done` or a watchdog timeout. Bank toggles (`ub_buf_sel`) are applied only while the buffer is idle.

---
 rtl/ub_access_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ub_access_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ub_access_arbiter.sv
// Round-robin, burst-locked arbiter for the unified-buffer command port.
// A won burst owns the buffer until ub_done or a watchdog abort; bank flips happen only while idle.
module ub_access_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*ADDR_W-1:0]   req_count,
  input  logic [NREQ*DATA_W-1:0]   req_wr_data,
  input  logic                     buf_toggle,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     timeout_err,
  output logic                     ub_rd_en,
  output logic                     ub_wr_en,
  output logic [ADDR_W-1:0]        ub_rd_addr,
  output logic [ADDR_W-1:0]        ub_wr_addr,
  output logic [ADDR_W-1:0]        ub_rd_count,
  output logic [ADDR_W-1:0]        ub_wr_count,
  output logic [DATA_W-1:0]        ub_wr_data,
  output logic                     ub_buf_sel,
  input  logic [DATA_W-1:0]        ub_rd_data,
  input  logic                     ub_rd_valid,
  input  logic                     ub_busy,
  input  logic                     ub_done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              owner_wr_q, owner_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              abort_q, abort_d;
  logic              pend_q, pend_d;
  logic              buf_sel_q, buf_sel_d;

  // Round-robin search upward from rr_ptr+1, wrapping modulo NREQ.
  logic             found;
  logic [IDX_W-1:0] pick;
  int               cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    owner_wr_d = owner_wr_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wd_d       = wd_q;
    abort_d    = abort_q;
    pend_d     = pend_q | buf_toggle;
    buf_sel_d  = buf_sel_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          // A pending flip blocks arbitration for this cycle even if ub_busy stalls it.
          if (!ub_busy) begin
            buf_sel_d = ~buf_sel_q;
            pend_d    = buf_toggle;
          end
        end else if (found) begin
          owner_d    = pick;
          rr_ptr_d   = pick;
          owner_wr_d = req_wr[pick];
          addr_d     = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          count_d    = req_count[int'(pick)*ADDR_W +: ADDR_W];
          abort_d    = 1'b0;
          wd_d       = '0;
          state_d    = (req_count[int'(pick)*ADDR_W +: ADDR_W] == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ub_done) begin
          state_d = S_FINISH;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= IDX_W'(NREQ - 1);
      owner_wr_q <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      wd_q       <= '0;
      abort_q    <= 1'b0;
      pend_q     <= 1'b0;
      buf_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_wr_q <= owner_wr_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wd_q       <= wd_d;
      abort_q    <= abort_d;
      pend_q     <= pend_d;
      buf_sel_q  <= buf_sel_d;
    end
  end

  always_comb begin
    grant       = '0;
    done        = '0;
    timeout_err = 1'b0;
    ub_rd_en    = 1'b0;
    ub_wr_en    = 1'b0;
    ub_rd_addr  = '0;
    ub_wr_addr  = '0;
    ub_rd_count = '0;
    ub_wr_count = '0;
    ub_wr_data  = '0;
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      grant      = NREQ'(1) << owner_q;
      ub_wr_data = req_wr_data[int'(owner_q)*DATA_W +: DATA_W];
    end
    if (state_q == S_ISSUE) begin
      ub_rd_en = ~owner_wr_q;
      ub_wr_en = owner_wr_q;
      if (owner_wr_q) begin
        ub_wr_addr  = addr_q;
        ub_wr_count = count_q;
      end else begin
        ub_rd_addr  = addr_q;
        ub_rd_count = count_q;
      end
    end
    if (state_q == S_FINISH) begin
      done        = NREQ'(1) << owner_q;
      timeout_err = abort_q;
    end
  end

  assign rd_valid   = grant & {NREQ{ub_rd_valid & ~owner_wr_q}};
  assign rd_data    = ub_rd_data;
  assign ub_buf_sel = buf_sel_q;

endmodule

// File: tb/tb_ub_access_arbiter.sv
// Directed self-checking bench for ub_access_arbiter (NREQ=3, TIMEOUT=8).
module tb_ub_access_arbiter;

  localparam int NREQ = 3, ADDR_W = 9, DATA_W = 256, TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req, req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr, req_count;
  logic [NREQ*DATA_W-1:0] req_wr_data;
  logic                   buf_toggle;
  logic [NREQ-1:0]        grant, done, rd_valid;
  logic [DATA_W-1:0]      rd_data, ub_wr_data, ub_rd_data;
  logic                   timeout_err, ub_rd_en, ub_wr_en, ub_buf_sel;
  logic [ADDR_W-1:0]      ub_rd_addr, ub_wr_addr, ub_rd_count, ub_wr_count;
  logic                   ub_rd_valid, ub_busy, ub_done;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_W-1:0] PAT_A5 = {32{8'hA5}};

  ub_access_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_count(req_count), .req_wr_data(req_wr_data), .buf_toggle(buf_toggle),
    .grant(grant), .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
    .timeout_err(timeout_err), .ub_rd_en(ub_rd_en), .ub_wr_en(ub_wr_en),
    .ub_rd_addr(ub_rd_addr), .ub_wr_addr(ub_wr_addr), .ub_rd_count(ub_rd_count),
    .ub_wr_count(ub_wr_count), .ub_wr_data(ub_wr_data), .ub_buf_sel(ub_buf_sel),
    .ub_rd_data(ub_rd_data), .ub_rd_valid(ub_rd_valid), .ub_busy(ub_busy),
    .ub_done(ub_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs driven after this are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant, check it, finish the burst with ub_done in the first WAIT cycle.
  task automatic serve(input string tag, input logic [NREQ-1:0] exp_g);
    int n = 0;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_grant"}, DATA_W'(grant), DATA_W'(exp_g));
    tick();
    ub_done = 1'b1;
    tick();
    ub_done = 1'b0;
    #1 check({tag, "_done"}, DATA_W'(done), DATA_W'(exp_g));
  endtask

  task automatic wait_grant();
    int n = 0;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "hang");
  end

  initial begin
    rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_count = '0; req_wr_data = '0;
    buf_toggle = 1'b0; ub_rd_data = '0; ub_rd_valid = 1'b0; ub_busy = 1'b0; ub_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_grant", DATA_W'(grant), '0);
    check("rst_done", DATA_W'(done), '0);
    check("rst_bufsel", DATA_W'(ub_buf_sel), '0);
    check("rst_rden", DATA_W'(ub_rd_en), '0);

    // Single read from requester 0, ub_done at cycle 6.
    tick();
    req_addr[0 +: ADDR_W] = 9'h012; req_count[0 +: ADDR_W] = 9'd4; req = 3'b001;
    #1 check("rd_c0_grant", DATA_W'(grant), '0);
    tick();
    check("rd_c1_grant", DATA_W'(grant), DATA_W'(3'b001));
    check("rd_c1_rden", DATA_W'(ub_rd_en), 1);
    check("rd_c1_wren", DATA_W'(ub_wr_en), 0);
    check("rd_c1_addr", DATA_W'(ub_rd_addr), DATA_W'(9'h012));
    check("rd_c1_count", DATA_W'(ub_rd_count), 4);
    req = '0;
    tick();
    check("rd_c2_rden", DATA_W'(ub_rd_en), 0);
    ub_rd_valid = 1'b1; ub_rd_data = 256'h1234_5678;
    #1 check("rd_c2_rdvalid", DATA_W'(rd_valid), DATA_W'(3'b001));
    check("rd_c2_rddata", rd_data, 256'h1234_5678);
    tick();
    ub_rd_valid = 1'b0;
    #1 check("rd_c3_rdvalid", DATA_W'(rd_valid), '0);
    repeat (3) tick();
    ub_done = 1'b1;
    #1 check("rd_c6_done", DATA_W'(done), '0);
    tick();
    ub_done = 1'b0;
    check("rd_c7_done", DATA_W'(done), DATA_W'(3'b001));
    check("rd_c7_grant", DATA_W'(grant), '0);
    tick();
    check("rd_c8_done", DATA_W'(done), '0);

    // Round-robin from reset with all requesters held high.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(9'h040 + i);
      req_count[i*ADDR_W +: ADDR_W] = 9'd1;
    end
    req = 3'b111;
    serve("rr0", 3'b001); serve("rr1", 3'b010); serve("rr2", 3'b100);
    serve("rr3", 3'b001); serve("rr4", 3'b010); serve("rr5", 3'b100);

    // Write burst from requester 1.
    req = 3'b010; req_wr = 3'b010;
    req_wr_data[1*DATA_W +: DATA_W] = PAT_A5;
    req_addr[1*ADDR_W +: ADDR_W] = 9'h0AB;
    wait_grant();
    ub_rd_valid = 1'b1;
    #1 check("wr_grant", DATA_W'(grant), DATA_W'(3'b010));
    check("wr_wren", DATA_W'(ub_wr_en), 1);
    check("wr_rden", DATA_W'(ub_rd_en), 0);
    check("wr_data", ub_wr_data, PAT_A5);
    check("wr_addr", DATA_W'(ub_wr_addr), DATA_W'(9'h0AB));
    check("wr_count", DATA_W'(ub_wr_count), 1);
    check("wr_rdvalid", DATA_W'(rd_valid), '0);
    tick();
    check("wr_wait_rdvalid", DATA_W'(rd_valid), '0);
    check("wr_wait_wren", DATA_W'(ub_wr_en), 0);
    ub_done = 1'b1;
    tick();
    ub_done = 1'b0; ub_rd_valid = 1'b0; req = '0; req_wr = '0;
    #1 check("wr_done", DATA_W'(done), DATA_W'(3'b010));
    check("wr_data_idle", ub_wr_data, '0);

    // Bank toggle pulsed twice during WAIT: one flip, only after done.
    req = 3'b101;
    wait_grant();
    check("tg_grant", DATA_W'(grant), DATA_W'(3'b100));
    tick();
    buf_toggle = 1'b1;
    #1 check("tg_wait_bufsel", DATA_W'(ub_buf_sel), 0);
    tick();
    buf_toggle = 1'b0;
    tick();
    buf_toggle = 1'b1; ub_done = 1'b1;
    tick();
    buf_toggle = 1'b0; ub_done = 1'b0;
    #1 check("tg_done", DATA_W'(done), DATA_W'(3'b100));
    check("tg_fin_bufsel", DATA_W'(ub_buf_sel), 0);
    tick();
    check("tg_idle_grant", DATA_W'(grant), '0);
    check("tg_idle_bufsel", DATA_W'(ub_buf_sel), 0);
    tick();
    check("tg_flip_bufsel", DATA_W'(ub_buf_sel), 1);
    check("tg_flip_grant", DATA_W'(grant), '0);
    tick();
    check("tg_delayed_grant", DATA_W'(grant), DATA_W'(3'b001));
    req = '0;
    tick();
    ub_done = 1'b1;
    tick();
    ub_done = 1'b0;
    #1 check("tg_done2", DATA_W'(done), DATA_W'(3'b001));
    tick(); tick();
    check("tg_single_flip", DATA_W'(ub_buf_sel), 1);

    // Watchdog abort, then ub_done coincident with the final count.
    req = 3'b001; req_count[0 +: ADDR_W] = 9'd2;
    wait_grant();
    req = '0;
    repeat (8) tick();
    check("to_last_wait_done", DATA_W'(done), '0);
    check("to_last_wait_grant", DATA_W'(grant), DATA_W'(3'b001));
    tick();
    check("to_done", DATA_W'(done), DATA_W'(3'b001));
    check("to_err", DATA_W'(timeout_err), 1);
    tick();
    check("to_err_clear", DATA_W'(timeout_err), 0);
    req = 3'b001;
    wait_grant();
    req = '0;
    repeat (8) tick();
    ub_done = 1'b1;
    tick();
    ub_done = 1'b0;
    #1 check("co_done", DATA_W'(done), DATA_W'(3'b001));
    check("co_err", DATA_W'(timeout_err), 0);

    // Zero-count burst, then reset in the middle of WAIT.
    tick();
    req_count[1*ADDR_W +: ADDR_W] = 9'd0; req = 3'b010;
    #1 check("zc_c0_strobe", DATA_W'({ub_rd_en, ub_wr_en}), '0);
    tick();
    check("zc_c1_done", DATA_W'(done), DATA_W'(3'b010));
    check("zc_c1_grant", DATA_W'(grant), '0);
    check("zc_c1_strobe", DATA_W'({ub_rd_en, ub_wr_en}), '0);
    req = 3'b011; req_count[0 +: ADDR_W] = 9'd1;
    tick();
    check("zc_c2_done", DATA_W'(done), '0);
    tick();
    check("zc_rr_advanced", DATA_W'(grant), DATA_W'(3'b001));
    tick();
    buf_toggle = 1'b1;
    tick();
    buf_toggle = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    #1 check("mr_grant", DATA_W'(grant), '0);
    check("mr_done", DATA_W'(done), '0);
    check("mr_bufsel", DATA_W'(ub_buf_sel), 0);
    check("mr_err", DATA_W'(timeout_err), 0);
    check("mr_strobe", DATA_W'({ub_rd_en, ub_wr_en}), '0);
    tick(); tick();
    check("mr_no_flip", DATA_W'(ub_buf_sel), 0);
    check("mr_no_done", DATA_W'(done), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
